// File: rtl/slow_mem_if.sv
// Line-memory bus between a cache (master) and the slow memory responder (slave).
// Handshake: a request is a level on mem_read or mem_write. The requester holds it until mem_ready, then drops it.
interface slow_mem_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         prot_err;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, prot_err
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, prot_err
    );
endinterface

// File: rtl/slow_mem_responder.sv
// Fixed-latency 128-bit line memory responder: IDLE -> WAIT -> DONE -> IDLE.
// Each accepted request gets exactly one mem_ready pulse.
module slow_mem_responder #(
    parameter int IDX_BITS = 8,
    parameter int LATENCY  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    slow_mem_if.slave  mem,
    output logic [1:0] o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_conflict;
    logic                  w_finish;
    logic [3:0]            r_cnt;
    logic                  r_op_write;
    logic [IDX_BITS-1:0]   r_idx;
    logic [127:0]          r_wdata;
    logic [127:0]          r_rdata;
    logic                  r_ready;
    logic                  r_prot_err;
    logic [127:0]          r_mem [2**IDX_BITS];
    logic                  w_unused_addr;

    // Upper address bits only alias; they never reach the array.
    assign w_unused_addr = ^mem.mem_addr[27:IDX_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = 1'b0;
        w_conflict = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept   = mem.mem_read ^ mem.mem_write;
                w_conflict = mem.mem_read & mem.mem_write;
            end
            S_WAIT:  w_finish = (r_cnt == 4'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_op_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_prot_err <= 1'b0;
        end else begin
            r_ready <= w_finish;
            if (w_conflict) r_prot_err <= 1'b1;
            if (w_accept) begin
                r_cnt      <= CNT_LOAD;
                r_op_write <= mem.mem_write;
                r_idx      <= mem.mem_addr[IDX_BITS-1:0];
                r_wdata    <= mem.mem_wdata;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_finish && !r_op_write) r_rdata <= r_mem[r_idx];
        end
    end

    // Array content survives reset; only a commit edge that has already happened sticks.
    always_ff @(posedge clk) begin
        if (w_finish && r_op_write) r_mem[r_idx] <= r_wdata;
    end

    assign mem.mem_rdata = r_rdata;
    assign mem.mem_ready = r_ready;
    assign mem.prot_err  = r_prot_err;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_slow_mem_responder.sv
// Directed bench for slow_mem_responder: latency, data paths, aliasing, protocol error, reset abort.
module tb_slow_mem_responder;
    localparam int LAT = 5;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;
    logic [127:0] rd;

    localparam logic [127:0] V_DEAD = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_BEEF;
    localparam logic [127:0] V_W34  = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    localparam logic [127:0] V_OLD  = 128'hA5A5_0040_0000_0000_0000_0000_0040_A5A5;
    localparam logic [127:0] V_NEW  = 128'h5A5A_FFFF_1234_5678_9ABC_DEF0_0040_5A5A;
    localparam logic [127:0] V_55   = 128'h5555_5555_0000_0000_0000_0000_5555_5555;

    slow_mem_if bus();

    slow_mem_responder #(.IDX_BITS(8), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request so it is sampled at the next edge, then walks LAT+1 edges checking the pulse.
    // At drop_at (a WAIT cycle) the request is withdrawn and addr/wdata are scrambled.
    task automatic do_req(input string tag, input logic rd_en, input logic wr_en,
                          input logic [27:0] addr, input logic [127:0] wd,
                          input int drop_at, output logic [127:0] rdata);
        bus.mem_read  = rd_en;
        bus.mem_write = wr_en;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        rdata = 'x;
        tick();
        chk({tag, "_accept_state"}, 128'(dbg_state), 128'd1);
        for (int i = 1; i <= LAT + 1; i++) begin
            tick();
            chk({tag, "_ready"}, 128'(bus.mem_ready), 128'(i == LAT));
            if (i == drop_at) begin
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
                bus.mem_addr  = 28'(($urandom_range(0, 255) << 4) | 1);
                bus.mem_wdata = {4{$urandom}};
            end
            if (i == LAT) begin
                rdata = bus.mem_rdata;
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
        end
        chk({tag, "_back_idle"}, 128'(dbg_state), 128'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ready", 128'(bus.mem_ready), 128'd0);
            chk("idle_rdata", bus.mem_rdata, 128'd0);
            chk("idle_prot",  128'(bus.prot_err), 128'd0);
        end

        // Preload and read back line 0x12
        do_req("wr12", 1'b0, 1'b1, 28'h12, V_DEAD, 0, rd);
        chk("rdata_after_wr", bus.mem_rdata, 128'd0);
        do_req("rd12", 1'b1, 1'b0, 28'h12, '0, 0, rd);
        chk("rd12_data", rd, V_DEAD);

        // Write/read 0x34 and its alias 0x134
        do_req("wr34", 1'b0, 1'b1, 28'h34, V_W34, 0, rd);
        do_req("rd34", 1'b1, 1'b0, 28'h34, '0, 0, rd);
        chk("rd34_data", rd, V_W34);
        do_req("rd134", 1'b1, 1'b0, 28'h134, '0, 0, rd);
        chk("rd134_alias", rd, V_W34);

        // rdata holds through a later write; write via alias lands on line 0x55
        do_req("wr155", 1'b0, 1'b1, 28'h155, V_55, 0, rd);
        chk("rdata_hold", bus.mem_rdata, V_W34);
        do_req("rd55", 1'b1, 1'b0, 28'h55, '0, 0, rd);
        chk("rd55_data", rd, V_55);

        // Read withdrawn after 2 WAIT cycles with address scrambled still completes from latched address
        do_req("rd12_drop", 1'b1, 1'b0, 28'h12, '0, 2, rd);
        chk("rd12_drop_data", rd, V_DEAD);
        tick();
        chk("no_second_txn", 128'(dbg_state), 128'd0);

        // Write withdrawn mid-WAIT with wdata scrambled commits the latched data
        do_req("wr34_drop", 1'b0, 1'b1, 28'h34, V_55, 3, rd);
        do_req("rd34b", 1'b1, 1'b0, 28'h34, '0, 0, rd);
        chk("rd34b_data", rd, V_55);

        // Protocol error: both requests high in IDLE
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("both_state", 128'(dbg_state), 128'd0);
            chk("both_ready", 128'(bus.mem_ready), 128'd0);
            chk("both_prot",  128'(bus.prot_err), 128'd1);
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        tick();
        chk("prot_sticky", 128'(bus.prot_err), 128'd1);
        do_req("rd12_after_err", 1'b1, 1'b0, 28'h12, '0, 0, rd);
        chk("rd_after_err_data", rd, V_DEAD);
        chk("prot_still", 128'(bus.prot_err), 128'd1);

        // Reset in the middle of a write keeps the old line contents
        do_req("wr40", 1'b0, 1'b1, 28'h40, V_OLD, 0, rd);
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h40;
        bus.mem_wdata = V_NEW;
        tick();
        chk("wr40b_accept", 128'(dbg_state), 128'd1);
        tick();
        tick();
        rst_n = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        chk("rst_state", 128'(dbg_state), 128'd0);
        chk("rst_ready", 128'(bus.mem_ready), 128'd0);
        chk("rst_prot",  128'(bus.prot_err), 128'd0);
        chk("rst_rdata", bus.mem_rdata, 128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk("post_rst_ready", 128'(bus.mem_ready), 128'd0);
        end
        do_req("rd40", 1'b1, 1'b0, 28'h40, '0, 0, rd);
        chk("rd40_old", rd, V_OLD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
